// File: rtl/mem_arbiter_4core_if.sv
// Bus bundle between the four cores, the arbiter and the shared RAM port.
// The slave modport is the arbiter's view and the master modport is the view
// of the environment that drives requests and supplies RAM read data.
interface mem_arbiter_4core_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [3:0]          req;
    logic [3:0]          req_we;
    logic [3:0]          req_fetch;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_wdata;
    logic [3:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  req, req_we, req_fetch, req_addr, req_wdata, mem_rdata,
        output ack, rdata, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req, req_we, req_fetch, req_addr, req_wdata, mem_rdata,
        input  ack, rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter_4core.sv
// Round-robin arbiter sharing one RAM port between four cores. Each access
// takes IDLE -> ACCESS -> DONE, with ack pulsed during DONE. A fetch that
// returns the halt word latches that core's sticky halted flag, and halted
// cores are excluded from arbitration.
module mem_arbiter_4core #(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_arbiter_4core_if.slave   bus,
    input  logic                 halt_clr,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic [3:0]           halted,
    output logic                 all_halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic       write_op;
    logic       fetch_op;
    logic [3:0] eligible;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic [3:0] halted_next;

    // Pick the first eligible core scanning upward from the round-robin pointer.
    always_comb begin
        eligible = bus.req & ~halted;
        winner   = rr_ptr;
        idx      = '0;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next halt flags: clear first so a halt detected in DONE on the same edge wins.
    always_comb begin
        halted_next = halted;
        if (halt_clr) begin
            halted_next = '0;
        end
        if (state == DONE && fetch_op && !write_op && bus.rdata == HALT_WORD) begin
            halted_next[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM with every output registered; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            write_op      <= 1'b0;
            fetch_op      <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            halted        <= '0;
            all_halted    <= 1'b0;
        end else begin
            halted     <= halted_next;
            all_halted <= &halted_next;
            bus.ack    <= '0;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        grant_id      <= winner;
                        bus.mem_addr  <= bus.req_addr[winner*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.req_wdata[winner*DATA_W +: DATA_W];
                        bus.mem_we    <= bus.req_we[winner];
                        write_op      <= bus.req_we[winner];
                        fetch_op      <= bus.req_fetch[winner];
                        busy          <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!write_op) begin
                        bus.rdata <= bus.mem_rdata;
                    end
                    bus.mem_we <= 1'b0;
                    bus.ack    <= 4'b0001 << grant_id;
                    state      <= DONE;
                end
                DONE: begin
                    rr_ptr <= grant_id + 2'd1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
